// File: rtl/dfdd_frame_sequencer.sv
// DFDD front-end frame sequencer: raster pixel streaming with line blanking,
// double-buffered pipeline coefficients and result-count based frame drain.
module dfdd_frame_sequencer #(
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480,
  parameter int FP_WIDTH_REG  = 16,
  parameter int LINE_GAP      = 4,
  parameter int DRAIN_TIMEOUT = 65535
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   cfg_we_i,
  input  logic [3:0]                             cfg_addr_i,
  input  logic [15:0]                            cfg_wdata_i,
  input  logic                                   start_i,
  input  logic [7:0]                             pix_plus_i,
  input  logic [7:0]                             pix_minus_i,
  input  logic                                   pix_valid_i,
  output logic                                   pix_ready_o,
  output logic [7:0]                             i_rho_plus_o,
  output logic [7:0]                             i_rho_minus_o,
  output logic [15:0]                            col_o,
  output logic [15:0]                            row_o,
  output logic                                   valid_o,
  input  logic                                   res_valid_i,
  output logic [1:0][2:0][FP_WIDTH_REG-1:0]      w_o,
  output logic [FP_WIDTH_REG-1:0]                w_t_o,
  output logic [1:0][FP_WIDTH_REG-1:0]           a_o,
  output logic [1:0][FP_WIDTH_REG-1:0]           b_o,
  output logic                                   busy_o,
  output logic                                   frame_done_o,
  output logic                                   timeout_o,
  output logic [15:0]                            frame_cnt_o
);

  localparam int TGT = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int RW  = $clog2(TGT + 1);

  localparam logic [RW-1:0] TGT_R      = RW'(TGT);
  localparam logic [15:0]   COL_LAST   = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0]   ROW_LAST   = 16'(IMAGE_HEIGHT - 1);
  localparam logic [15:0]   GAP_LAST   = 16'(LINE_GAP - 1);
  localparam logic [31:0]   DRAIN_LAST = 32'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    GAP,
    DRAIN
  } state_t;

  state_t state;

  logic [1:0][2:0][FP_WIDTH_REG-1:0] sh_w;
  logic [FP_WIDTH_REG-1:0]           sh_wt;
  logic [1:0][FP_WIDTH_REG-1:0]      sh_a;
  logic [1:0][FP_WIDTH_REG-1:0]      sh_b;
  logic                              commit_pending;

  logic [15:0]   col_cnt;
  logic [15:0]   row_cnt;
  logic [15:0]   gap_cnt;
  logic [31:0]   drain_cnt;
  logic [RW-1:0] res_cnt;

  logic                    accept;
  logic                    commit_wr;
  logic                    start_ok;
  logic                    res_en;
  logic [RW-1:0]           res_nxt;
  logic                    col_end;
  logic                    row_end;
  logic [FP_WIDTH_REG-1:0] cfg_val;

  assign cfg_val   = FP_WIDTH_REG'(cfg_wdata_i);
  assign accept    = (state == STREAM) && pix_ready_o && pix_valid_i;
  assign commit_wr = cfg_we_i && (cfg_addr_i == 4'd15);
  assign start_ok  = (state == IDLE) && start_i;
  assign res_en    = res_valid_i && (state != IDLE);
  assign col_end   = (col_cnt == COL_LAST);
  assign row_end   = (row_cnt == ROW_LAST);

  always_comb begin
    res_nxt = res_cnt;
    if (res_en && (res_cnt != TGT_R))
      res_nxt = res_cnt + 1'b1;
  end

  // Shadow bank: written at any time, only copied to the outputs at start.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sh_w  <= '0;
      sh_wt <= '0;
      sh_a  <= '0;
      sh_b  <= '0;
    end else if (cfg_we_i) begin
      case (cfg_addr_i)
        4'd0:    sh_w[0][0] <= cfg_val;
        4'd1:    sh_w[0][1] <= cfg_val;
        4'd2:    sh_w[0][2] <= cfg_val;
        4'd3:    sh_w[1][0] <= cfg_val;
        4'd4:    sh_w[1][1] <= cfg_val;
        4'd5:    sh_w[1][2] <= cfg_val;
        4'd6:    sh_wt      <= cfg_val;
        4'd7:    sh_a[0]    <= cfg_val;
        4'd8:    sh_a[1]    <= cfg_val;
        4'd9:    sh_b[0]    <= cfg_val;
        4'd10:   sh_b[1]    <= cfg_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      commit_pending <= 1'b0;
      w_o            <= '0;
      w_t_o          <= '0;
      a_o            <= '0;
      b_o            <= '0;
      pix_ready_o    <= 1'b0;
      i_rho_plus_o   <= '0;
      i_rho_minus_o  <= '0;
      col_o          <= '0;
      row_o          <= '0;
      valid_o        <= 1'b0;
      busy_o         <= 1'b0;
      frame_done_o   <= 1'b0;
      timeout_o      <= 1'b0;
      frame_cnt_o    <= '0;
      col_cnt        <= '0;
      row_cnt        <= '0;
      gap_cnt        <= '0;
      drain_cnt      <= '0;
      res_cnt        <= '0;
    end else begin
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
      timeout_o    <= 1'b0;
      res_cnt      <= res_nxt;

      // A commit written on the start cycle waits for the next frame.
      if (start_ok) begin
        if (commit_pending) begin
          w_o   <= sh_w;
          w_t_o <= sh_wt;
          a_o   <= sh_a;
          b_o   <= sh_b;
        end
        commit_pending <= commit_wr;
      end else if (commit_wr) begin
        commit_pending <= 1'b1;
      end

      if (accept) begin
        i_rho_plus_o  <= pix_plus_i;
        i_rho_minus_o <= pix_minus_i;
        col_o         <= col_cnt;
        row_o         <= row_cnt;
        valid_o       <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (start_i) begin
            state       <= STREAM;
            pix_ready_o <= 1'b1;
            busy_o      <= 1'b1;
            col_cnt     <= '0;
            row_cnt     <= '0;
            res_cnt     <= '0;
          end
        end
        STREAM: begin
          if (accept) begin
            if (col_end) begin
              col_cnt <= '0;
              if (row_end) begin
                row_cnt     <= '0;
                state       <= DRAIN;
                pix_ready_o <= 1'b0;
                drain_cnt   <= '0;
              end else begin
                row_cnt <= row_cnt + 1'b1;
                if (LINE_GAP > 0) begin
                  state       <= GAP;
                  pix_ready_o <= 1'b0;
                  gap_cnt     <= '0;
                end
              end
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state       <= STREAM;
            pix_ready_o <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (res_nxt == TGT_R) begin
            frame_done_o <= 1'b1;
            state        <= IDLE;
            busy_o       <= 1'b0;
            frame_cnt_o  <= frame_cnt_o + 1'b1;
          end else if (drain_cnt == DRAIN_LAST) begin
            timeout_o   <= 1'b1;
            state       <= IDLE;
            busy_o      <= 1'b0;
            frame_cnt_o <= frame_cnt_o + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dfdd_frame_sequencer.md
Name: dfdd_frame_sequencer

Overview:
- Front-end controller for the dual-scale fp16 DFDD pipeline.
- Accepts uint8 rho+/rho- pixel pairs over a valid/ready handshake and emits them as a raster stream with col/row/valid, inserting line blanking between rows.
- Holds the pipeline coefficients (w, w_t, a, b) in double-buffered registers; shadow values become active only at a frame start.
- Counts pipeline results to report frame completion or drain timeout.

Parameters:
- IMAGE_WIDTH, 640, pixels per row (>=2)
- IMAGE_HEIGHT, 480, rows per frame (>=2)
- FP_WIDTH_REG, 16, coefficient width (fp16)
- LINE_GAP, 4, blanking cycles inserted after each row's last pixel (0 allowed)
- DRAIN_TIMEOUT, 65535, max cycles in DRAIN before abort

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-low reset
- cfg_we_i  in  1  config write strobe
- cfg_addr_i  in  4  config address
- cfg_wdata_i  in  16  config write data
- start_i  in  1  single-cycle frame start request
- pix_plus_i  in  8  rho+ pixel
- pix_minus_i  in  8  rho- pixel
- pix_valid_i  in  1  input pixel valid
- pix_ready_o  out  1  sequencer accepts pixel
- i_rho_plus_o  out  8  pixel to pipeline
- i_rho_minus_o  out  8  pixel to pipeline
- col_o  out  16  column of emitted pixel
- row_o  out  16  row of emitted pixel
- valid_o  out  1  emitted pixel valid
- res_valid_i  in  1  pipeline output valid (valid_o of dual-scale wrapper)
- w_o  out  [2][3]xFP_WIDTH_REG  active w kernel per scale
- w_t_o  out  FP_WIDTH_REG  active w_t
- a_o  out  [2]xFP_WIDTH_REG  active a per scale
- b_o  out  [2]xFP_WIDTH_REG  active b per scale
- busy_o  out  1  high in any state other than IDLE
- frame_done_o  out  1  one-cycle pulse: frame fully drained
- timeout_o  out  1  one-cycle pulse: drain timed out
- frame_cnt_o  out  16  completed frame count (done or timeout), wraps at 2^16

Behaviour:
- Reset (rst_i==0 at a clk_i edge) clears everything to 0:
  - all outputs, including pix_ready_o, valid_o, col_o, row_o, busy_o and frame_cnt_o
  - shadow and active registers, and the commit_pending flag
  - state returns to IDLE
  - Reset mid-frame abandons the frame with no done or timeout pulse.
- Config map (cfg_we_i=1 writes shadow only):
  - 0-2: w[0][0..2]
  - 3-5: w[1][0..2]
  - 6: w_t
  - 7-8: a[0..1]
  - 9-10: b[0..1]
  - 15: sets commit_pending (data ignored)
  - 11-14: ignored
- Config writes are legal in any state and never disturb the active outputs.
- FSM IDLE -> STREAM on start_i.
  - On that edge, if commit_pending is set, active<=shadow and commit_pending is cleared.
  - start_i outside IDLE is ignored.
  - A commit write in the same cycle as start_i is not applied this frame; it stays pending.
- STREAM:
  - pix_ready_o=1 except during blanking.
  - On pix_valid_i&&pix_ready_o: register the pixel to i_rho_*_o, drive col/row from internal counters, and assert valid_o for 1 cycle (latency 1).
  - col increments; at col==IMAGE_WIDTH-1, col wraps to 0 and row increments.
- GAP (reached from STREAM after a row's last pixel, except the final row):
  - pix_ready_o=0 for exactly LINE_GAP cycles, then back to STREAM.
  - With LINE_GAP==0, skip GAP entirely.
- DRAIN:
  - Entered from STREAM after pixel (IMAGE_WIDTH-1, IMAGE_HEIGHT-1) is accepted; pix_ready_o=0.
  - Ends when the result count reaches IMAGE_WIDTH*IMAGE_HEIGHT: pulse frame_done_o, increment frame_cnt_o, go to IDLE.
  - If DRAIN_TIMEOUT cycles elapse first: pulse timeout_o, increment frame_cnt_o, go to IDLE.
- Result counter:
  - Counts res_valid_i in STREAM, GAP and DRAIN.
  - Cleared on frame start.
  - Saturates at IMAGE_WIDTH*IMAGE_HEIGHT.
  - res_valid_i in IDLE is ignored.
- If the count reaches target on the same cycle the timeout expires, done wins and timeout_o stays 0.
- When pix_ready_o=0, valid_o stays 0 and col/row hold their last values.

Test Plan:
- IMAGE_WIDTH=4, IMAGE_HEIGHT=2, LINE_GAP=2; start, pix_valid_i held 1 -> 8 valid_o pulses:
  - col 0,1,2,3,0,1,2,3 and row 0,0,0,0,1,1,1,1
  - pix_ready_o low exactly 2 cycles between the row 0 and row 1 pulses
  - data matches input, 1-cycle latency
- Write addr 0=16'h3C00 and addr 15, then start -> w_o[0][0]=16'h3C00 on the cycle after start. A later write of addr 0=16'h4000 mid-frame leaves w_o at 16'h3C00 until the next commit+start.
- Feed 8 res_valid_i pulses during DRAIN -> one frame_done_o pulse on the cycle after the 8th, busy_o falls, frame_cnt_o=1.
- DRAIN_TIMEOUT=10 with no res_valid_i -> timeout_o pulse after 10 DRAIN cycles, frame_done_o never asserts, frame_cnt_o=1, state IDLE.
- start_i asserted during STREAM and pixel-valid gaps (pix_valid_i toggling) -> no restart; col/row advance only on accepted pixels; 8 total valid_o.
- rst_i=0 mid-row (col=2) -> next cycle all outputs 0 and FSM IDLE; a new start produces col 0,row 0 first.
